// File: rtl/sdram_port_emu_if.sv
// rtl/sdram_port_emu_if.sv - user-side request/ack port of the SDRAM emulator
interface sdram_port_emu_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 21
);
    logic              sdram_wr_req;
    logic              sdram_wr_ack;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic [9:0]        sdram_wr_burst;
    logic [DATA_W-1:0] sdram_din;
    logic              sdram_rd_req;
    logic              sdram_rd_ack;
    logic [ADDR_W-1:0] sdram_rd_addr;
    logic [9:0]        sdram_rd_burst;
    logic [DATA_W-1:0] sdram_dout;
    logic              sdram_init_done;

    // FIFO control side: issues burst requests and write data
    modport master (
        output sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
        output sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
        input  sdram_wr_ack, sdram_rd_ack, sdram_dout, sdram_init_done
    );

    // Emulator side: acknowledges bursts and returns read data
    modport slave (
        input  sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
        input  sdram_rd_req, sdram_rd_addr, sdram_rd_burst,
        output sdram_wr_ack, sdram_rd_ack, sdram_dout, sdram_init_done
    );
endinterface

// File: rtl/sdram_port_emu.sv
// rtl/sdram_port_emu.sv - block-RAM backed stand-in for the SDRAM controller user port
module sdram_port_emu #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 21,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 100,
    parameter int ACK_LAT     = 3,
    parameter int REC_CYCLES  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    sdram_port_emu_if.slave bus,
    output logic [15:0] wr_bursts,
    output logic [15:0] rd_bursts
);
    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WR_WAIT,
        S_WR_DATA,
        S_WR_TAIL,
        S_RD_WAIT,
        S_RD_DATA,
        S_RECOVER
    } state_t;

    state_t            state;
    logic [INIT_W-1:0] init_cnt;
    logic [3:0]        wait_cnt;
    logic [9:0]        data_cnt;
    logic [3:0]        rec_cnt;
    logic [MEM_AW-1:0] wr_ptr;
    logic [MEM_AW-1:0] rd_ptr;
    logic              wr_ack;
    logic              rd_ack;
    logic              wr_ack_d;
    logic              init_done;
    logic [DATA_W-1:0] dout;
    logic              rd_fetch;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    // Only the low MEM_AW address bits select a word; the rest is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.sdram_wr_addr[ADDR_W-1:MEM_AW],
                                bus.sdram_rd_addr[ADDR_W-1:MEM_AW]};

    assign bus.sdram_wr_ack    = wr_ack;
    assign bus.sdram_rd_ack    = rd_ack;
    assign bus.sdram_dout      = dout;
    assign bus.sdram_init_done = init_done;

    // Fetch the next read word one cycle ahead so it lands on dout with its ack
    always_comb begin
        rd_fetch = 1'b0;
        if (state == S_RD_WAIT && wait_cnt == 4'd1) begin
            rd_fetch = 1'b1;
        end else if (state == S_RD_DATA && data_cnt != 10'd1) begin
            rd_fetch = 1'b1;
        end
    end

    // Write port: the word presented in the cycle after each ack is stored; not reset so contents survive
    always_ff @(posedge sys_clk) begin
        if (wr_ack_d) begin
            mem[wr_ptr] <= bus.sdram_din;
        end
    end

    // Registered read port feeding sdram_dout, held between fetches
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            dout <= '0;
        end else if (rd_fetch) begin
            dout <= mem[rd_ptr];
        end
    end

    // Port sequencer: init delay, arbitration, ack timing, recovery and burst counting
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            wait_cnt  <= '0;
            data_cnt  <= '0;
            rec_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            wr_ack_d  <= 1'b0;
            wr_bursts <= '0;
            rd_bursts <= '0;
        end else begin
            wr_ack_d <= wr_ack;
            if (wr_ack_d) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (state)
                S_INIT: begin
                    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.sdram_wr_req) begin
                        wr_ptr   <= bus.sdram_wr_addr[MEM_AW-1:0];
                        data_cnt <= bus.sdram_wr_burst;
                        if (bus.sdram_wr_burst == 10'd0) begin
                            rec_cnt   <= 4'(REC_CYCLES);
                            wr_bursts <= wr_bursts + 16'd1;
                            state     <= S_RECOVER;
                        end else begin
                            wait_cnt <= 4'(ACK_LAT - 1);
                            state    <= S_WR_WAIT;
                        end
                    end else if (bus.sdram_rd_req) begin
                        rd_ptr   <= bus.sdram_rd_addr[MEM_AW-1:0];
                        data_cnt <= bus.sdram_rd_burst;
                        if (bus.sdram_rd_burst == 10'd0) begin
                            rec_cnt   <= 4'(REC_CYCLES);
                            rd_bursts <= rd_bursts + 16'd1;
                            state     <= S_RECOVER;
                        end else begin
                            wait_cnt <= 4'(ACK_LAT - 1);
                            state    <= S_RD_WAIT;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        wr_ack <= 1'b1;
                        state  <= S_WR_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_WR_DATA: begin
                    if (data_cnt == 10'd1) begin
                        wr_ack <= 1'b0;
                        state  <= S_WR_TAIL;
                    end else begin
                        data_cnt <= data_cnt - 1'b1;
                    end
                end
                S_WR_TAIL: begin
                    rec_cnt   <= 4'(REC_CYCLES);
                    wr_bursts <= wr_bursts + 16'd1;
                    state     <= S_RECOVER;
                end
                S_RD_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        rd_ack <= 1'b1;
                        state  <= S_RD_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (data_cnt == 10'd1) begin
                        rd_ack    <= 1'b0;
                        rec_cnt   <= 4'(REC_CYCLES);
                        rd_bursts <= rd_bursts + 16'd1;
                        state     <= S_RECOVER;
                    end else begin
                        data_cnt <= data_cnt - 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (rec_cnt == 4'd1) begin
                        state <= S_IDLE;
                    end else begin
                        rec_cnt <= rec_cnt - 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_emu.sv
// tb/tb_sdram_port_emu.sv - self-checking bench for sdram_port_emu
module tb_sdram_port_emu;
    localparam int DW   = 16;
    localparam int AW   = 21;
    localparam int INIT = 100;
    localparam int LAT  = 3;
    localparam int REC  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] wr_bursts;
    logic [15:0] rd_bursts;

    always #5 clk = ~clk;

    sdram_port_emu_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sdram_port_emu #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_AW(10),
        .INIT_CYCLES(INIT), .ACK_LAT(LAT), .REC_CYCLES(REC)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus),
        .wr_bursts (wr_bursts),
        .rd_bursts (rd_bursts)
    );

    int          checks = 0;
    int          failures = 0;
    logic [15:0] ref_mem   [0:1023];
    bit          ref_valid [0:1023];
    int          exp_wr = 0;
    int          exp_rd = 0;
    logic [15:0] wdata [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("ack_exclusive", {31'b0, bus.sdram_wr_ack & bus.sdram_rd_ack}, 32'd0);
    endtask

    // Count INIT cycles from cycle 0 (first cycle after the last reset edge).
    task automatic run_init();
        for (int c = 0; c <= INIT; c++) begin
            if (c == INIT - 1) bus.sdram_wr_req = 1'b0;
            chk("init_done", {31'b0, bus.sdram_init_done}, {31'b0, (c >= INIT)});
            chk("init_no_ack", {31'b0, bus.sdram_wr_ack}, 32'd0);
            if (c < INIT) step();
        end
    endtask

    // Starts in an IDLE cycle; returns in the first IDLE cycle after recovery.
    task automatic do_write(input logic [20:0] addr, input int n);
        int lat;
        int acks;
        int idx;
        int a;
        bit prev;
        bit cur;
        bus.sdram_wr_addr  = addr;
        bus.sdram_wr_burst = 10'(n);
        bus.sdram_wr_req   = 1'b1;
        step();
        bus.sdram_wr_req   = 1'b0;
        bus.sdram_wr_addr  = 21'($urandom);
        bus.sdram_wr_burst = 10'($urandom);
        if (n == 0) begin
            exp_wr++;
            chk("wr_bursts_zero", {16'b0, wr_bursts}, exp_wr);
            repeat (REC) begin
                chk("wr_zero_no_ack", {31'b0, bus.sdram_wr_ack}, 32'd0);
                step();
            end
            return;
        end
        lat = 1;
        while (bus.sdram_wr_ack !== 1'b1 && lat < 64) begin
            chk("wr_wait_no_rd_ack", {31'b0, bus.sdram_rd_ack}, 32'd0);
            step();
            lat++;
        end
        chk("wr_latency", lat, LAT);
        acks = 0;
        idx  = 0;
        prev = 1'b0;
        for (int g = 0; g < 1100; g++) begin
            if (prev && idx < wdata.size()) begin
                bus.sdram_din = wdata[idx];
                a = (int'(addr[9:0]) + idx) % 1024;
                ref_mem[a]   = wdata[idx];
                ref_valid[a] = 1'b1;
                idx++;
            end else begin
                bus.sdram_din = 16'($urandom);
            end
            cur = bus.sdram_wr_ack;
            if (!cur) break;
            acks++;
            prev = cur;
            step();
        end
        chk("wr_acks", acks, n);
        step();
        bus.sdram_din = 16'($urandom);
        exp_wr++;
        chk("wr_bursts", {16'b0, wr_bursts}, exp_wr);
        repeat (REC) begin
            chk("wr_rec_no_ack", {31'b0, bus.sdram_wr_ack | bus.sdram_rd_ack}, 32'd0);
            step();
        end
    endtask

    task automatic do_read(input logic [20:0] addr, input int n);
        int lat;
        int acks;
        int a;
        bus.sdram_rd_addr  = addr;
        bus.sdram_rd_burst = 10'(n);
        bus.sdram_rd_req   = 1'b1;
        step();
        bus.sdram_rd_req   = 1'b0;
        bus.sdram_rd_addr  = 21'($urandom);
        bus.sdram_rd_burst = 10'($urandom);
        if (n == 0) begin
            exp_rd++;
            chk("rd_bursts_zero", {16'b0, rd_bursts}, exp_rd);
            repeat (REC) begin
                chk("rd_zero_no_ack", {31'b0, bus.sdram_rd_ack}, 32'd0);
                step();
            end
            return;
        end
        lat = 1;
        while (bus.sdram_rd_ack !== 1'b1 && lat < 64) begin
            step();
            lat++;
        end
        chk("rd_latency", lat, LAT);
        acks = 0;
        for (int g = 0; g < 1100; g++) begin
            if (bus.sdram_rd_ack !== 1'b1) break;
            a = (int'(addr[9:0]) + acks) % 1024;
            if (ref_valid[a]) chk("rd_data", {16'b0, bus.sdram_dout}, {16'b0, ref_mem[a]});
            acks++;
            step();
        end
        chk("rd_acks", acks, n);
        exp_rd++;
        chk("rd_bursts", {16'b0, rd_bursts}, exp_rd);
        repeat (REC) step();
    endtask

    initial begin
        int acks;
        int idx;
        int n;
        bit prev;
        logic [20:0] addr;

        bus.sdram_wr_req   = 1'b1;
        bus.sdram_wr_addr  = 21'h10;
        bus.sdram_wr_burst = 10'd4;
        bus.sdram_din      = '0;
        bus.sdram_rd_req   = 1'b0;
        bus.sdram_rd_addr  = '0;
        bus.sdram_rd_burst = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_wr_bursts", {16'b0, wr_bursts}, 32'd0);
        chk("rst_rd_bursts", {16'b0, rd_bursts}, 32'd0);
        chk("rst_dout", {16'b0, bus.sdram_dout}, 32'd0);
        chk("rst_rd_ack", {31'b0, bus.sdram_rd_ack}, 32'd0);
        run_init();

        wdata = {};
        for (int i = 0; i < 8; i++) wdata.push_back(16'hA000 + 16'(i));
        do_write(21'h10, 8);
        do_read(21'h10, 8);

        wdata = {};
        for (int i = 0; i < 6; i++) wdata.push_back(16'($urandom));
        bus.sdram_rd_addr  = 21'h10;
        bus.sdram_rd_burst = 10'd8;
        bus.sdram_rd_req   = 1'b1;
        do_write(21'h40, 6);
        do_read(21'h10, 8);
        do_read(21'h40, 6);

        wdata = {16'd1, 16'd2, 16'd3, 16'd4};
        do_write(21'h1FFFFE, 4);
        chk("wrap_ref_3fe", {16'b0, ref_mem[1022]}, 32'd1);
        chk("wrap_ref_001", {16'b0, ref_mem[1]}, 32'd4);
        do_read(21'h0AB3FE, 4);

        do_read(21'h123, 0);

        wdata = {};
        for (int i = 0; i < 1023; i++) wdata.push_back(16'($urandom));
        do_write(21'h155, 1023);
        do_read(21'h155, 1023);

        wdata = {};
        for (int i = 0; i < 16; i++) wdata.push_back(16'($urandom));
        bus.sdram_wr_addr  = 21'h1E0200;
        bus.sdram_wr_burst = 10'd16;
        bus.sdram_wr_req   = 1'b1;
        step();
        bus.sdram_wr_req = 1'b0;
        for (int g = 0; g < 64 && bus.sdram_wr_ack !== 1'b1; g++) step();
        acks = 0;
        idx  = 0;
        prev = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (prev) begin
                bus.sdram_din = wdata[idx];
                ref_mem[(512 + idx) % 1024]   = wdata[idx];
                ref_valid[(512 + idx) % 1024] = 1'b1;
                idx++;
            end else begin
                bus.sdram_din = 16'($urandom);
            end
            if (bus.sdram_wr_ack !== 1'b1) break;
            acks++;
            if (acks == 5) break;
            prev = 1'b1;
            step();
        end
        chk("abort_acks_seen", acks, 5);
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        exp_wr = 0;
        exp_rd = 0;
        chk("abort_ack_stops", {31'b0, bus.sdram_wr_ack}, 32'd0);
        chk("abort_wr_bursts", {16'b0, wr_bursts}, 32'd0);
        chk("abort_init_done", {31'b0, bus.sdram_init_done}, 32'd0);
        run_init();
        do_read(21'h000200, 4);

        for (int it = 0; it < 12; it++) begin
            n    = $urandom_range(0, 24);
            addr = 21'($urandom);
            wdata = {};
            for (int i = 0; i < n; i++) wdata.push_back(16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                bus.sdram_rd_addr  = {11'($urandom), addr[9:0]};
                bus.sdram_rd_burst = 10'(n);
                bus.sdram_rd_req   = 1'b1;
            end
            do_write(addr, n);
            do_read({11'($urandom), 10'(addr[9:0] + 10'($urandom_range(0, 4)))},
                    $urandom_range(0, 24));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_port_emu.md
Name: sdram_port_emu

Overview:
- Cycle-accurate, single-clock stand-in for the SDRAM controller's user-side request/ack port, backed by on-chip block RAM.
- It is the responder for the FIFO control block's write and read burst requests. It lets the dual-port FIFO/ping-pong logic run in simulation or on FPGA without the SDRAM chip or its controller.
- Implements init delay, write priority, burst ack timing, address wrap and inter-burst recovery.

Parameters:
- DATA_W, 16, data width of sdram_din/sdram_dout
- ADDR_W, 21, width of request addresses
- MEM_AW, 10, log2 of emulated RAM depth in words; only the low MEM_AW address bits are used
- INIT_CYCLES, 100, cycles from reset release to sdram_init_done
- ACK_LAT, 3, cycles from request acceptance to first ack; legal range 2..15
- REC_CYCLES, 2, idle recovery cycles after every burst; legal range 1..15

Ports:
- sys_clk  in  1  single clock
- sys_rst_n  in  1  reset, synchronous, active-low
- sdram_wr_req  in  1  write burst request (level)
- sdram_wr_ack  out  1  write ack, high once per word
- sdram_wr_addr  in  ADDR_W  write burst start address
- sdram_wr_burst  in  10  write burst length in words
- sdram_din  in  DATA_W  write data
- sdram_rd_req  in  1  read burst request (level)
- sdram_rd_ack  out  1  read ack; read data valid
- sdram_rd_addr  in  ADDR_W  read burst start address
- sdram_rd_burst  in  10  read burst length in words
- sdram_dout  out  DATA_W  read data
- sdram_init_done  out  1  emulated init complete
- wr_bursts  out  16  completed write bursts, wraps at 2^16
- rd_bursts  out  16  completed read bursts, wraps at 2^16

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - All outputs go to 0; state = INIT; init counter cleared.
  - RAM contents are NOT cleared.
  - Reset mid-burst aborts the burst immediately, with no further acks and no counter increment.
- INIT:
  - Counts INIT_CYCLES clocks after reset release.
  - sdram_init_done rises on the clock edge ending cycle INIT_CYCLES and stays high until the next reset.
  - Requests are ignored during INIT.
- IDLE: requests are sampled each cycle.
  - If sdram_wr_req=1, accept the write (write has priority over read when both are high).
  - Else if sdram_rd_req=1, accept the read.
  - On acceptance, latch the address low MEM_AW bits and the burst length. Later changes on addr/burst inputs have no effect.
- Zero-length burst: burst=0 is accepted, produces no ack, does not touch RAM, then goes to RECOVER. The burst counter still increments.
- WR_WAIT / RD_WAIT: hold ACK_LAT-1 cycles after the acceptance cycle T. The first ack is high in cycle T+ACK_LAT.
- WR_DATA:
  - sdram_wr_ack is high for exactly N consecutive cycles (N = latched burst).
  - Word i (0-based) is taken from sdram_din in the cycle after the i-th ack cycle. This models a normal-mode FIFO read driven by ack.
  - Word i is written to RAM[(base+i) mod 2^MEM_AW].
- WR_TAIL: one cycle after the last ack, captures word N-1, then goes to RECOVER.
- RD_DATA:
  - sdram_rd_ack is high for exactly N consecutive cycles.
  - sdram_dout holds RAM[(base+i) mod 2^MEM_AW] in the same cycle as the i-th ack. The RAM read is issued one cycle early to cover synchronous RAM latency.
  - sdram_dout is don't-care when ack=0 but is held at its last value.
- Address wrap: a burst crossing 2^MEM_AW-1 continues at 0. Upper address bits are ignored.
- Read of a location written in the immediately preceding write burst returns the new data, because REC_CYCLES≥1 guarantees the write has landed.
- RECOVER: REC_CYCLES cycles with no acks, then IDLE. wr_bursts or rd_bursts increments on entry to RECOVER.
- Request deassertion:
  - Dropping a request after acceptance does not shorten the burst.
  - A request still high on return to IDLE is accepted again as a new burst.
- Acks are mutually exclusive; at most one of wr_ack/rd_ack is high in any cycle.
- Throughput per burst: 1 acceptance + (ACK_LAT-1) wait + N data + (1 tail, write only) + REC_CYCLES.

Test Plan:
- Init: release reset at cycle 0, defaults -> sdram_init_done=0 through cycle 99 and 1 from cycle 100. wr_req held high during INIT produces no ack.
- Write then read:
  - Write, burst=8, addr=0x10, din=0xA000+i fed one cycle after each ack -> wr_ack high exactly 8 cycles starting 3 after acceptance; wr_bursts=1.
  - Read, burst=8, addr=0x10 -> rd_ack 8 cycles with dout=0xA000..0xA007 aligned to ack; rd_bursts=1.
- Priority: wr_req and rd_req rise in the same cycle -> write burst completes first, then after 2 recovery cycles the read is accepted. Acks never overlap.
- Wrap: write burst=4 at addr=0x1FFFFE with data 1,2,3,4 -> RAM[0x3FE]=1, [0x3FF]=2, [0x000]=3, [0x001]=4. A read burst=4 at 0x3FE returns 1,2,3,4.
- Abort: assert reset during the 5th ack of a 16-word write -> acks stop the next cycle, wr_bursts=0, init_done=0 for 100 cycles. Words 0..3 remain readable afterward.
- Edge cases:
  - burst=0 read -> no rd_ack, rd_bursts increments, return to IDLE after 2 recovery cycles.
  - burst=1023 write -> exactly 1023 ack cycles.
